// File: rtl/iddmm_task_initiator.sv
// Job sequencer for the IDDMM core: streams x/y/m into the core, runs one task,
// buffers the result words and drains them to the host. Optional: IDDMM_M_CACHE_EN.
module iddmm_task_initiator #(
  parameter int K = 128,
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef IDDMM_M_CACHE_EN
  input  logic                 load_m,
`endif
  output logic                 busy,
  input  logic [K-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         m1,
  output logic [2:0]           wr_ena,
  output logic [$clog2(N)-1:0] wr_addr,
  output logic [K-1:0]         wr_x,
  output logic [K-1:0]         wr_y,
  output logic [K-1:0]         wr_m,
  output logic [K-1:0]         wr_m1,
  output logic                 task_req,
  input  logic                 task_grant,
  input  logic                 task_end,
  input  logic [K-1:0]         task_res,
  output logic [K-1:0]         res_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_last,
  output logic                 done
);

  // state   | meaning
  // IDLE    | waiting for start
  // LOAD_X  | accepting x words
  // LOAD_Y  | accepting y words
  // LOAD_M  | accepting m words
  // REQ     | requesting the core
  // WAIT    | granted, waiting for the first result word
  // COLLECT | storing result words
  // DRAIN   | all results stored, emptying the FIFO
  localparam int AW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE, LOAD_X, LOAD_Y, LOAD_M, REQ, WAIT, COLLECT, DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          task_req_nxt;
  logic          load_m_r;
  logic          accept, push, pop, last_word;

  logic [K-1:0]  fifo_mem [N];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;

  assign accept    = in_valid && in_ready;
  assign last_word = (cnt == AW'(N - 1));
  assign push      = task_end && (state == WAIT || state == COLLECT);
  assign pop       = res_valid && res_ready;
  assign res_valid = (fifo_cnt != '0);
  assign res_data  = res_valid ? fifo_mem[rd_ptr] : '0;
  // The FIFO is empty at the start of every job, so the read pointer is the word index.
  assign res_last  = res_valid && (rd_ptr == AW'(N - 1));
  assign done      = pop && res_last;
  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD_X) || (state == LOAD_Y) || (state == LOAD_M);

`ifdef IDDMM_M_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst)
      load_m_r <= 1'b0;
    else if (state == IDLE && start)
      load_m_r <= load_m;
  end
`else
  assign load_m_r = 1'b1;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    task_req_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_X;
          cnt_nxt   = '0;
        end
      end
      LOAD_X, LOAD_Y, LOAD_M: begin
        if (accept) begin
          cnt_nxt = cnt + AW'(1);
          if (last_word) begin
            cnt_nxt = '0;
            if (state == LOAD_X)
              state_nxt = LOAD_Y;
            else if (state == LOAD_Y)
              state_nxt = load_m_r ? LOAD_M : REQ;
            else
              state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // task_req is registered so it rises one cycle after the final core write.
        if (task_req && task_grant)
          state_nxt = WAIT;
        else
          task_req_nxt = 1'b1;
      end
      WAIT: begin
        if (task_end) begin
          state_nxt = COLLECT;
          cnt_nxt   = AW'(1);
        end
      end
      COLLECT: begin
        if (task_end) begin
          cnt_nxt = cnt + AW'(1);
          if (last_word) begin
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      task_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      task_req <= task_req_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ena  <= '0;
      wr_addr <= '0;
      wr_x    <= '0;
      wr_y    <= '0;
      wr_m    <= '0;
      wr_m1   <= '0;
    end else begin
      wr_ena <= '0;
      if (accept) begin
        wr_addr <= cnt;
        wr_m1   <= m1;
        case (state)
          LOAD_X: begin
            wr_ena <= 3'b001;
            wr_x   <= in_data;
          end
          LOAD_Y: begin
            wr_ena <= 3'b010;
            wr_y   <= in_data;
          end
          default: begin
            wr_ena <= 3'b100;
            wr_m   <= in_data;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= task_res;
  end

endmodule

// File: tb/tb_iddmm_task_initiator.sv
// Scoreboard bench for iddmm_task_initiator (K=128, N=4): directed jobs, a monitor
// pops expected core writes and result words as the DUT presents them.
module tb_iddmm_task_initiator;
  localparam int K  = 128;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam logic [K-1:0] M1_VAL = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

  logic          clk, rst, start;
  logic          busy, in_valid, in_ready;
  logic [K-1:0]  in_data, m1;
  logic [2:0]    wr_ena;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_x, wr_y, wr_m, wr_m1;
  logic          task_req, task_grant, task_end;
  logic [K-1:0]  task_res, res_data;
  logic          res_valid, res_ready, res_last, done;
`ifdef IDDMM_M_CACHE_EN
  logic          load_m;
`endif

  iddmm_task_initiator #(.K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef IDDMM_M_CACHE_EN
    .load_m(load_m),
`endif
    .busy(busy), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .m1(m1), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .wr_m(wr_m), .wr_m1(wr_m1), .task_req(task_req), .task_grant(task_grant),
    .task_end(task_end), .task_res(task_res), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last), .done(done)
  );

  typedef struct packed {
    logic [2:0]    ena;
    logic [AW-1:0] addr;
    logic [K-1:0]  data;
  } wr_t;
  typedef struct packed {
    logic [K-1:0] data;
    logic         last;
  } rs_t;

  wr_t exp_wr[$];
  rs_t exp_rs[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every core write and every result pop is matched against the queues.
  wr_t          mw;
  rs_t          mr;
  logic [K-1:0] wsel;
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_ena != 3'b000) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got ena=%0h addr=%0h expected no write", wr_ena, wr_addr);
        end else begin
          mw = exp_wr.pop_front();
          case (wr_ena)
            3'b001:  wsel = wr_x;
            3'b010:  wsel = wr_y;
            3'b100:  wsel = wr_m;
            default: wsel = '0;
          endcase
          chk("wr_ena", wr_ena, mw.ena);
          chk("wr_addr", wr_addr, mw.addr);
          chk("wr_data", wsel, mw.data);
          chk("wr_m1", wr_m1, M1_VAL);
        end
      end
      if (res_valid && res_ready) begin
        if (exp_rs.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0h expected no result", res_data);
        end else begin
          mr = exp_rs.pop_front();
          chk("res_data", res_data, mr.data);
          chk("res_last_done", {res_last, done}, {mr.last, mr.last});
        end
      end
    end
  end

  task automatic run_job(input logic [K-1:0] base, input logic [K-1:0] rbase,
                         input bit stray, input bit hold, input bit rst_wait, input bit lm);
    int nw;
    int t;
    nw = lm ? 3 * N : 2 * N;
`ifdef IDDMM_M_CACHE_EN
    load_m = lm;
`endif
    for (int i = 0; i < nw; i++)
      exp_wr.push_back(wr_t'{3'(1 << (i / N)), AW'(i % N), base + K'(i)});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < nw; i++) begin
      in_valid = 1'b1;
      in_data  = base + K'(i);
      if (stray && i == 1) begin
        task_grant = 1'b1;
        task_end   = 1'b1;
        task_res   = 128'hDEAD;
      end
      if (stray && i == N + 1) start = 1'b1;
      @(negedge clk);
      chk("in_ready", in_ready, 1);
      if (stray && i == 2) begin
        chk("stray_res_valid", res_valid, 0);
        chk("stray_task_req", task_req, 0);
      end
      @(posedge clk); #1;
      task_grant = 1'b0;
      task_end   = 1'b0;
      start      = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("req_low_in_last_write", task_req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_after_last_write", task_req, 1);
    repeat (3) @(posedge clk);
    #1 task_grant = 1'b1;
    @(negedge clk);
    chk("req_held", task_req, 1);
    @(posedge clk); #1;
    task_grant = 1'b0;
    @(negedge clk);
    chk("req_dropped", task_req, 0);
    chk("busy_in_wait", busy, 1);
    if (rst_wait) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("outputs_after_rst_in_wait",
          {busy, in_ready, wr_ena, task_req, res_valid, res_last, done, wr_addr,
           wr_x, wr_y, wr_m, wr_m1, res_data}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    res_ready = !hold;
    for (int j = 0; j < N; j++)
      exp_rs.push_back(rs_t'{rbase + K'(j), (j == N - 1)});
    for (int j = 0; j < N; j++) begin
      @(posedge clk); #1;
      task_end = 1'b1;
      task_res = rbase + K'(j);
    end
    @(posedge clk); #1;
    task_end = 1'b0;
    if (hold) begin
      @(negedge clk);
      chk("held_res_valid", res_valid, 1);
      chk("held_no_done", done, 0);
      @(posedge clk); #1;
      res_ready = 1'b1;
    end
    t = 0;
    @(negedge clk);
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end else begin
      chk("busy_at_done", busy, 1);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
    end
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("res_queue_empty", exp_rs.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    m1         = M1_VAL;
    task_grant = 1'b0;
    task_end   = 1'b0;
    task_res   = '0;
    res_ready  = 1'b1;
`ifdef IDDMM_M_CACHE_EN
    load_m     = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs",
        {busy, in_ready, wr_ena, task_req, res_valid, res_last, done, wr_addr,
         wr_x, wr_y, wr_m, wr_m1, res_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(128'h1,   128'hA0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(128'h101, 128'hB0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_job(128'h201, 128'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_job(128'h301, 128'hD0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_job(128'h401, 128'hE0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef IDDMM_M_CACHE_EN
    run_job(128'h501, 128'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(128'h601, 128'h70, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iddmm_task_initiator.md
IDDMM_TASK_INITIATOR -- requirements
Module: iddmm_task_initiator

Interface
REQ-001 SHALL have parameter K, default 128: bits per operand word.
REQ-002 SHALL have parameter N, default 32: words per operand; N is a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle job start pulse.
REQ-006 SHALL have port busy, output, 1: high from job acceptance until the job finishes.
REQ-007 SHALL have ports in_data (input, K), in_valid (input, 1) and in_ready (output, 1): operand stream, low words first, in the order x, then y, then m.
REQ-008 SHALL have port m1, input, K: Montgomery constant; it SHALL be held stable while busy.
REQ-009 SHALL have ports wr_ena (output, 3), wr_addr (output, $clog2(N)), wr_x (output, K), wr_y (output, K), wr_m (output, K) and wr_m1 (output, K): core write port; wr_ena bit 0 selects x, bit 1 selects y, bit 2 selects m.
REQ-010 SHALL have ports task_req (output, 1), task_grant (input, 1), task_end (input, 1) and task_res (input, K): core task handshake.
REQ-011 SHALL have ports res_data (output, K), res_valid (output, 1), res_ready (input, 1) and res_last (output, 1): result stream to the host.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when the job completes.

Function
REQ-013 SHALL implement states IDLE, LOAD_X, LOAD_Y, LOAD_M, REQ, WAIT, COLLECT and DRAIN.
REQ-014 SHALL move IDLE->LOAD_X on start; start in any other state SHALL be ignored.
REQ-015 SHALL assert in_ready only in LOAD_X, LOAD_Y and LOAD_M; a word is accepted on in_valid&&in_ready.
REQ-016 SHALL, for each accepted word, register one write to the core in the next cycle:
- one-hot wr_ena matching the current LOAD state;
- wr_addr equal to the word index 0..N-1;
- the word on the matching wr_x, wr_y or wr_m;
- wr_m1 equal to m1.
REQ-017 SHALL drive wr_ena to 0 in all cycles with no write.
REQ-018 SHALL advance LOAD_X->LOAD_Y->LOAD_M->REQ after word N-1 of each operand; the word counter SHALL wrap to 0 at each advance.
REQ-019 SHALL raise task_req the cycle after the last m write and hold it until task_grant is sampled high; task_req SHALL be low the following cycle and the state SHALL become WAIT.
REQ-020 SHALL treat task_end as high for exactly N consecutive cycles, carrying result word 0..N-1 (low first) on task_res; the first task_end cycle moves WAIT->COLLECT.
REQ-021 SHALL store each task_end word in an N-deep result FIFO; since depth equals N, no overflow is possible.
REQ-022 SHALL move COLLECT->DRAIN after the Nth word is stored.
REQ-023 SHALL present the FIFO head on res_data, with res_valid = FIFO not empty; a word pops on res_valid&&res_ready, and draining may overlap COLLECT.
REQ-024 SHALL assert res_last with word N-1.
REQ-025 SHALL, on the pop of word N-1, pulse done, deassert busy in the next cycle and return to IDLE.
REQ-026 SHALL ignore task_grant outside REQ and task_end outside WAIT/COLLECT.
REQ-027 SHALL process a simultaneous push and pop in the same cycle with the FIFO count unchanged.

Reset
REQ-028 SHALL, on rst at any point including mid-job:
- go to IDLE;
- clear the counters and the FIFO;
- drive busy, in_ready, wr_ena, task_req, res_valid, res_last and done to 0;
- drive wr_addr, wr_x, wr_y, wr_m, wr_m1 and res_data to 0.

Configuration
REQ-029 SHALL, with IDDMM_M_CACHE_EN defined, add input load_m (1 bit, sampled on start); when load_m is 0, LOAD_Y SHALL go directly to REQ and no m or m1 writes SHALL be issued (2N words per job).
REQ-030 SHALL, without IDDMM_M_CACHE_EN, have no load_m port, always load 3N words, and always pass through LOAD_M.

Verification
REQ-031 SHALL be covered by: K=128, N=4, start, 12 words 1..12 with in_valid held high -> writes x=1..4, y=5..8, m=9..12 at addresses 0..3 on consecutive cycles; task_req high the cycle after the last write.
REQ-032 SHALL be covered by: grant 3 cycles after req, then task_end for 4 cycles with 0xA0..0xA3 and res_ready held high -> res_data 0xA0..0xA3, res_last on 0xA3, done pulse, busy low the next cycle.
REQ-033 SHALL be covered by: res_ready low until all 4 results are stored, then high -> the 4 words come out in order with no loss, and done fires on the pop of the 4th word.
REQ-034 SHALL be covered by: start during LOAD_Y, plus a stray task_grant and a stray task_end during LOAD_X -> no state change and no extra writes.
REQ-035 SHALL be covered by: rst asserted in WAIT -> all outputs 0 the next cycle; a new job afterwards completes correctly.
REQ-036 SHALL be covered by: with IDDMM_M_CACHE_EN and load_m=0, 8 words -> only x and y are written, and task_req follows the 8th write.
